sdhci_obi_responder: RTL and testbench
======================================

SDHCI_OBI_RESPONDER -- requirements
Module: sdhci_obi_responder

Interface
REQ-001 SHALL have parameter obi_req_t, default logic, OBI request struct with req, a.{addr,we,be,wdata,aid} and rready.
REQ-002 SHALL have parameter obi_rsp_t, default logic, OBI response struct with gnt, rvalid, r.{rdata,rid,err}.
REQ-003 SHALL have parameter RegAddrWidth, default 8, byte-address width of the SDHCI register space.
REQ-004 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_ni  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port obi_req_i  input  obi_req_t  OBI request from the initiator.
REQ-007 SHALL have port obi_rsp_o  output  obi_rsp_t  OBI response to the initiator.
REQ-008 SHALL have ports reg_valid_o (output, 1, access pending), reg_addr_o (output, RegAddrWidth, word-aligned byte address), reg_we_o (output, 1), reg_be_o (output, 4), reg_wdata_o (output, 32).
REQ-009 SHALL have ports reg_ready_i (input, 1, access complete), reg_rdata_i (input, 32), reg_error_i (input, 1).

Function
REQ-010 SHALL implement FSM states IDLE, ACCESS and ERR_RSP; reset state IDLE.
REQ-011 SHALL drive obi_rsp_o.gnt = obi_req_i.req when state is IDLE and the response FIFO is not full, else 0; gnt is combinational.
REQ-012 SHALL capture a.we, a.be, a.wdata, a.aid and a.addr[RegAddrWidth-1:2] on the req&gnt cycle (cycle N).
REQ-013 SHALL go IDLE->ACCESS at N+1 if a.addr[31:RegAddrWidth]==0 and be!=0, and assert reg_valid_o from N+1 with stable outputs until reg_ready_i.
REQ-014 SHALL, on reg_valid_o & reg_ready_i, push {rdata = we ? 0 : reg_rdata_i, err = reg_error_i, rid} into the response FIFO and return to IDLE the following cycle.
REQ-015 SHALL go IDLE->ERR_RSP when a.addr[31:RegAddrWidth]!=0; it pushes {rdata=0, err=1}, issues no register access and returns to IDLE.
REQ-016 SHALL treat be==0 as a no-op that pushes {rdata=0, err=0} via ERR_RSP with no register access.
REQ-017 SHALL drive obi_rsp_o.rvalid = FIFO not empty, with r.rdata/r.err/r.rid from the FIFO head.
REQ-018 SHALL give minimum latency: gnt at N, reg_valid_o at N+1, rvalid at N+2 with reg_ready_i=1 at N+1; error/no-op rvalid at N+2.
REQ-019 SHALL allow a FIFO push and pop in the same cycle (count unchanged), including when the FIFO is full.
REQ-020 SHALL drive reg_valid_o=0 and reg_we_o=0 in every state except ACCESS.

Reset
REQ-021 SHALL, asynchronously on rst_ni=0, force state IDLE, flush the FIFO, and drive gnt, rvalid, reg_valid_o and reg_we_o to 0 and all data outputs to 0.
REQ-022 SHALL drop a pending register access when reset asserts mid-ACCESS and produce no response for it after reset.

Configuration
REQ-023 SHALL honour macro SDHCI_OBI_RREADY_EN.
- Defined: response FIFO is 2 deep; pop when rvalid & obi_req_i.rready; gnt is blocked when the FIFO is full.
- Undefined: rready is ignored; FIFO is 1 deep and pops every cycle rvalid=1, so each response is held for exactly one cycle.

Verification
REQ-024 SHALL cover: write addr 0x02C, be 0010, wdata 0x0000_8000 -> reg_addr_o 0x2C, reg_be_o 0010, reg_valid_o at N+1; rvalid at N+2 with err 0.
REQ-025 SHALL cover: read addr 0x030 with reg_ready_i delayed 3 cycles and reg_rdata_i 0x8000_0001 -> rvalid at N+5 with rdata 0x8000_0001 and rid equal to aid.
REQ-026 SHALL cover: read addr 0x100 (RegAddrWidth 8) -> no reg_valid_o; rvalid at N+2 with err 1 and rdata 0.
REQ-027 SHALL cover: with SDHCI_OBI_RREADY_EN defined, rready=0 and three back-to-back reads -> two responses queued, third gnt held at 0 until rready=1.
REQ-028 SHALL cover: rst_ni pulsed low during ACCESS -> reg_valid_o and gnt drop immediately; no rvalid after release.
REQ-029 SHALL cover: write with be 0000 -> no register access; rvalid at N+2 with err 0.

Source files
------------

// File: rtl/sdhci_obi_responder.sv
// OBI subordinate that forwards single accesses onto the SDHCI register port.
// Optional SDHCI_OBI_RREADY_EN: rready back-pressure with a 2-deep response FIFO.
package sdhci_obi_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [3:0]  aid;
  } obi_a_t;

  typedef struct packed {
    logic   req;
    obi_a_t a;
    logic   rready;
  } obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [3:0]  rid;
    logic        err;
  } obi_r_t;

  typedef struct packed {
    logic   gnt;
    logic   rvalid;
    obi_r_t r;
  } obi_rsp_t;

endpackage

module sdhci_obi_responder #(
  parameter type obi_req_t = sdhci_obi_pkg::obi_req_t,
  parameter type obi_rsp_t = sdhci_obi_pkg::obi_rsp_t,
  parameter int unsigned RegAddrWidth = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  obi_req_t                obi_req_i,
  output obi_rsp_t                obi_rsp_o,
  output logic                    reg_valid_o,
  output logic [RegAddrWidth-1:0] reg_addr_o,
  output logic                    reg_we_o,
  output logic [3:0]              reg_be_o,
  output logic [31:0]             reg_wdata_o,
  input  logic                    reg_ready_i,
  input  logic [31:0]             reg_rdata_i,
  input  logic                    reg_error_i
);

`ifdef SDHCI_OBI_RREADY_EN
  localparam int Depth = 2;
`else
  localparam int Depth = 1;
`endif
  localparam int IdW  = $bits(obi_req_i.a.aid);
  localparam int EntW = 33 + IdW;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ERR_RSP
  } state_t;

  state_t state_q, state_d;

  logic [RegAddrWidth-3:0] addr_q;
  logic                    we_q;
  logic [3:0]              be_q;
  logic [31:0]             wdata_q;
  logic [IdW-1:0]          aid_q;
  logic                    err_q;

  logic [EntW-1:0] mem_q [Depth];
  logic [EntW-1:0] mem_d [Depth];
  logic [1:0]      cnt_q, cnt_d;
  logic [EntW-1:0] push_ent;

  logic full, empty, push, pop;
  logic gnt, oob, noop;
  logic unused_in;

  assign unused_in = ^{obi_req_i.rready, obi_req_i.a.addr[1:0]};

  assign full  = (cnt_q == 2'(Depth));
  assign empty = (cnt_q == 2'd0);
  assign oob   = (obi_req_i.a.addr >> RegAddrWidth) != '0;
  assign noop  = (obi_req_i.a.be == 4'b0000);
  assign gnt   = rst_ni & obi_req_i.req
               & (state_q == IDLE) & ~full;

`ifdef SDHCI_OBI_RREADY_EN
  assign pop = ~empty & obi_req_i.rready;
`else
  assign pop = ~empty;
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Capture the granted request; it stays stable through ACCESS
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      aid_q   <= '0;
      err_q   <= 1'b0;
    end else if (gnt) begin
      addr_q  <= obi_req_i.a.addr[RegAddrWidth-1:2];
      we_q    <= obi_req_i.a.we;
      be_q    <= obi_req_i.a.be;
      wdata_q <= obi_req_i.a.wdata;
      aid_q   <= obi_req_i.a.aid;
      err_q   <= oob;
    end
  end

  // Next state and response push
  always_comb begin
    state_d  = state_q;
    push     = 1'b0;
    push_ent = '0;
    unique case (state_q)
      IDLE: begin
        if (gnt) begin
          state_d = (oob | noop) ? ERR_RSP : ACCESS;
        end
      end
      ACCESS: begin
        if (reg_ready_i) begin
          push     = 1'b1;
          push_ent = {aid_q, reg_error_i,
                      we_q ? 32'h0 : reg_rdata_i};
          state_d  = IDLE;
        end
      end
      ERR_RSP: begin
        push     = 1'b1;
        push_ent = {aid_q, err_q, 32'h0};
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift-down response FIFO; head always in slot 0
  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (pop) begin
      for (int i = 0; i < Depth - 1; i++) begin
        mem_d[i] = mem_q[i+1];
      end
      mem_d[Depth-1] = '0;
      cnt_d = cnt_d - 2'd1;
    end
    if (push && (cnt_d != 2'(Depth))) begin
      for (int i = 0; i < Depth; i++) begin
        if (cnt_d == 2'(i)) mem_d[i] = push_ent;
      end
      cnt_d = cnt_d + 2'd1;
    end
  end

  // FIFO storage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

  // OBI response, data zeroed while nothing is valid
  always_comb begin
    obi_rsp_o        = '0;
    obi_rsp_o.gnt    = gnt;
    obi_rsp_o.rvalid = ~empty;
    if (!empty) begin
      {obi_rsp_o.r.rid,
       obi_rsp_o.r.err,
       obi_rsp_o.r.rdata} = mem_q[0];
    end
  end

  assign reg_valid_o = (state_q == ACCESS);
  assign reg_we_o    = reg_valid_o & we_q;
  assign reg_addr_o  = {addr_q, 2'b00};
  assign reg_be_o    = be_q;
  assign reg_wdata_o = wdata_q;

endmodule

// File: tb/tb_sdhci_obi_responder.sv
// Bench for sdhci_obi_responder: queue-based response model plus
// directed vectors with literal expectations.
`timescale 1ns/1ps
module tb_sdhci_obi_responder;
  import sdhci_obi_pkg::*;

`ifdef SDHCI_OBI_RREADY_EN
  localparam int CAP = 2;
  localparam bit RR  = 1'b1;
`else
  localparam int CAP = 1;
  localparam bit RR  = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  obi_req_t    req;
  obi_rsp_t    rsp;
  logic        reg_valid, reg_we, reg_ready, reg_error;
  logic [7:0]  reg_addr;
  logic [3:0]  reg_be;
  logic [31:0] reg_wdata, reg_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdhci_obi_responder #(
    .obi_req_t   (obi_req_t),
    .obi_rsp_t   (obi_rsp_t),
    .RegAddrWidth(8)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .obi_req_i  (req),
    .obi_rsp_o  (rsp),
    .reg_valid_o(reg_valid),
    .reg_addr_o (reg_addr),
    .reg_we_o   (reg_we),
    .reg_be_o   (reg_be),
    .reg_wdata_o(reg_wdata),
    .reg_ready_i(reg_ready),
    .reg_rdata_i(reg_rdata),
    .reg_error_i(reg_error)
  );

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", n, act, exp);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  rid;
  } resp_t;

  resp_t       mq[$];
  int          m_kind = 0;   // 0 none, 1 register access, 2 error/no-op
  logic [31:0] m_addr, m_wdata;
  logic        m_we, m_err;
  logic [3:0]  m_be, m_aid;
  resp_t       m_r;
  logic        m_g;
  int          m_nk;

  function automatic logic exp_gnt();
    return rst_n && req.req && m_kind == 0 && mq.size() < CAP;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_kind = 0;
    end else begin
      m_g  = exp_gnt();
      m_nk = m_kind;
      if (mq.size() > 0 && (!RR || req.rready)) void'(mq.pop_front());
      if (m_kind == 1 && reg_ready) begin
        m_r.rdata = m_we ? 32'h0 : reg_rdata;
        m_r.err   = reg_error;
        m_r.rid   = m_aid;
        mq.push_back(m_r);
        m_nk = 0;
      end else if (m_kind == 2) begin
        m_r = '{32'h0, m_err, m_aid};
        mq.push_back(m_r);
        m_nk = 0;
      end
      if (m_g) begin
        m_addr  = req.a.addr;
        m_we    = req.a.we;
        m_be    = req.a.be;
        m_wdata = req.a.wdata;
        m_aid   = req.a.aid;
        m_err   = (req.a.addr[31:8] != 0);
        m_nk    = (m_err || req.a.be == 0) ? 2 : 1;
      end
      m_kind = m_nk;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("gnt", 32'(rsp.gnt), 32'(exp_gnt()));
    chk("rvalid", 32'(rsp.rvalid), 32'(mq.size() > 0));
    chk("reg_valid", 32'(reg_valid), 32'(m_kind == 1));
    chk("reg_we", 32'(reg_we), 32'(m_kind == 1 && m_we));
    if (m_kind == 1) begin
      chk("reg_addr", 32'(reg_addr), {24'h0, m_addr[7:2], 2'b00});
      chk("reg_be", 32'(reg_be), 32'(m_be));
      chk("reg_wdata", reg_wdata, m_wdata);
    end
    if (mq.size() > 0) begin
      chk("rdata", rsp.r.rdata, mq[0].rdata);
      chk("err", 32'(rsp.r.err), 32'(mq[0].err));
      chk("rid", 32'(rsp.r.rid), 32'(mq[0].rid));
    end
  end

  // ---------------- stimulus ----------------
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] a, input logic we,
                       input logic [3:0] be, input logic [31:0] wd,
                       input logic [3:0] id);
    req.req     = 1'b1;
    req.a.addr  = a;
    req.a.we    = we;
    req.a.be    = be;
    req.a.wdata = wd;
    req.a.aid   = id;
  endtask

  logic [31:0] vaddr [6] = '{32'h04, 32'h08, 32'hFC,
                             32'h1000, 32'h14, 32'h03};
  logic        vwe   [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [3:0]  vbe   [6] = '{4'hF, 4'h1, 4'hF, 4'hF, 4'h0, 4'hC};
  logic [31:0] vrd   [6] = '{32'h5, 32'hCAFE0001, 32'h12345678,
                             32'h9, 32'h7, 32'h1};
  logic        verr  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  int          vdly  [6] = '{0, 2, 1, 0, 0, 1};

  initial begin
    rst_n      = 1'b0;
    req        = '0;
    req.req    = 1'b1;
    req.rready = 1'b1;
    reg_ready  = 1'b0;
    reg_rdata  = '0;
    reg_error  = 1'b0;
    repeat (2) nxt();
    smp();
    chk("rst_gnt", 32'(rsp.gnt), 0);
    chk("rst_rvalid", 32'(rsp.rvalid), 0);
    chk("rst_reg_valid", 32'(reg_valid), 0);
    chk("rst_reg_addr", 32'(reg_addr), 0);
    chk("rst_rdata", rsp.r.rdata, 0);
    nxt();
    req.req = 1'b0;
    rst_n   = 1'b1;
    nxt();

    // Write 0x2C, minimum latency
    issue(32'h2C, 1'b1, 4'b0010, 32'h0000_8000, 4'd3);
    reg_ready = 1'b1;
    smp();
    chk("t1_gnt", 32'(rsp.gnt), 1);
    nxt();
    req.req = 1'b0;
    smp();
    chk("t1_valid", 32'(reg_valid), 1);
    chk("t1_addr", 32'(reg_addr), 32'h2C);
    chk("t1_be", 32'(reg_be), 32'h2);
    chk("t1_we", 32'(reg_we), 1);
    chk("t1_wdata", reg_wdata, 32'h8000);
    nxt();
    smp();
    chk("t1_rvalid", 32'(rsp.rvalid), 1);
    chk("t1_err", 32'(rsp.r.err), 0);
    chk("t1_rid", 32'(rsp.r.rid), 3);
    chk("t1_model_q", 32'(mq.size()), 1);
    nxt();
    smp();
    chk("t1_rvalid_off", 32'(rsp.rvalid), 0);

    // Read 0x30, ready delayed three cycles
    reg_ready = 1'b0;
    nxt();
    issue(32'h30, 1'b0, 4'hF, 32'h0, 4'd5);
    smp();
    chk("t2_gnt", 32'(rsp.gnt), 1);
    nxt();
    req.req = 1'b0;
    smp();
    chk("t2_valid1", 32'(reg_valid), 1);
    chk("t2_we", 32'(reg_we), 0);
    nxt();
    nxt();
    smp();
    chk("t2_valid3", 32'(reg_valid), 1);
    chk("t2_rvalid3", 32'(rsp.rvalid), 0);
    nxt();
    reg_ready = 1'b1;
    reg_rdata = 32'h8000_0001;
    nxt();
    reg_ready = 1'b0;
    smp();
    chk("t2_rvalid", 32'(rsp.rvalid), 1);
    chk("t2_rdata", rsp.r.rdata, 32'h8000_0001);
    chk("t2_rid", 32'(rsp.r.rid), 5);

    // Out-of-range read
    nxt();
    issue(32'h100, 1'b0, 4'hF, 32'h0, 4'd6);
    reg_ready = 1'b1;
    reg_rdata = 32'hDEAD_BEEF;
    smp();
    chk("t3_gnt", 32'(rsp.gnt), 1);
    nxt();
    req.req = 1'b0;
    smp();
    chk("t3_valid", 32'(reg_valid), 0);
    nxt();
    smp();
    chk("t3_rvalid", 32'(rsp.rvalid), 1);
    chk("t3_err", 32'(rsp.r.err), 1);
    chk("t3_rdata", rsp.r.rdata, 0);
    chk("t3_rid", 32'(rsp.r.rid), 6);
    reg_ready = 1'b0;

    // Write with be 0000
    nxt();
    issue(32'h10, 1'b1, 4'h0, 32'hAAAA, 4'd7);
    smp();
    chk("t4_gnt", 32'(rsp.gnt), 1);
    nxt();
    req.req = 1'b0;
    smp();
    chk("t4_valid", 32'(reg_valid), 0);
    chk("t4_we", 32'(reg_we), 0);
    nxt();
    smp();
    chk("t4_rvalid", 32'(rsp.rvalid), 1);
    chk("t4_err", 32'(rsp.r.err), 0);
    chk("t4_rid", 32'(rsp.r.rid), 7);

    // Back-to-back reads with rready low
    nxt();
    reg_ready  = 1'b1;
    req.rready = 1'b0;
    issue(32'h40, 1'b0, 4'hF, 32'h0, 4'd1);
    smp();
    chk("t5_gnt0", 32'(rsp.gnt), 1);
    nxt();
    req.a.aid = 4'd2;
    smp();
    chk("t5_gnt1", 32'(rsp.gnt), 0);
`ifdef SDHCI_OBI_RREADY_EN
    nxt();
    smp();
    chk("t5_gnt2", 32'(rsp.gnt), 1);
    chk("t5_rid2", 32'(rsp.r.rid), 1);
    nxt();
    req.a.aid = 4'd3;
    smp();
    chk("t5_gnt3", 32'(rsp.gnt), 0);
    nxt();
    smp();
    chk("t5_gnt4", 32'(rsp.gnt), 0);
    chk("t5_model_full", 32'(mq.size()), 2);
    nxt();
    smp();
    chk("t5_gnt5", 32'(rsp.gnt), 0);
    chk("t5_rid5", 32'(rsp.r.rid), 1);
    nxt();
    req.rready = 1'b1;
    smp();
    chk("t5_gnt6", 32'(rsp.gnt), 0);
    nxt();
    smp();
    chk("t5_gnt7", 32'(rsp.gnt), 1);
    chk("t5_rid7", 32'(rsp.r.rid), 2);
    nxt();
    req.req = 1'b0;
    nxt();
    smp();
    chk("t5_rid9", 32'(rsp.r.rid), 3);
`else
    nxt();
    smp();
    chk("t5_gnt2", 32'(rsp.gnt), 0);
    chk("t5_rvalid2", 32'(rsp.rvalid), 1);
    chk("t5_rid2", 32'(rsp.r.rid), 1);
    nxt();
    smp();
    chk("t5_gnt3", 32'(rsp.gnt), 1);
    chk("t5_rvalid3", 32'(rsp.rvalid), 0);
    nxt();
    req.req = 1'b0;
    nxt();
    smp();
    chk("t5_rvalid5", 32'(rsp.rvalid), 1);
    chk("t5_rid5", 32'(rsp.r.rid), 2);
    nxt();
    smp();
    chk("t5_rvalid6", 32'(rsp.rvalid), 0);
    req.rready = 1'b1;
`endif
    reg_ready = 1'b0;
    repeat (3) nxt();

    // Vector table, checked by the model
    for (int v = 0; v < 6; v++) begin
      bit got;
      got = 1'b0;
      issue(vaddr[v], vwe[v], vbe[v], 32'hA5A5_0000 + v, 4'(v + 8));
      for (int k = 0; k < 20 && !got; k++) begin
        smp();
        if (rsp.gnt) got = 1'b1;
        nxt();
      end
      req.req = 1'b0;
      if (!got) chk("vec_gnt_timeout", 0, 1);
      repeat (vdly[v]) nxt();
      reg_ready = 1'b1;
      reg_rdata = vrd[v];
      reg_error = verr[v];
      nxt();
      reg_ready = 1'b0;
      reg_error = 1'b0;
      repeat (3) nxt();
    end

    // Reset pulse during ACCESS
    issue(32'h20, 1'b1, 4'hF, 32'h1234, 4'd9);
    smp();
    chk("t6_gnt", 32'(rsp.gnt), 1);
    nxt();
    smp();
    chk("t6_valid", 32'(reg_valid), 1);
    nxt();
    rst_n = 1'b0;
    #1;
    chk("t6_valid_drop", 32'(reg_valid), 0);
    chk("t6_we_drop", 32'(reg_we), 0);
    chk("t6_gnt_drop", 32'(rsp.gnt), 0);
    nxt();
    req.req   = 1'b0;
    reg_ready = 1'b1;
    rst_n     = 1'b1;
    for (int k = 0; k < 5; k++) begin
      smp();
      chk("t6_no_rvalid", 32'(rsp.rvalid), 0);
      nxt();
    end
    reg_ready = 1'b0;

    repeat (2) nxt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
